cdf_store_packer: RTL and testbench

Parametrised CDF write-back stage: sits at the tail of the CDF pipeline and replaces the single-result-per-beat store with a packing store. Per-element results are narrowed to a lane width, merged into wide bus words by element address, buffered in a small FIFO, and written to memory under a ready/valid handshake with per-lane write mask. It reports `done` when all accepted results have been written.

---
 rtl/cdf_store_packer_if.sv | 32 +++
 rtl/cdf_store_packer.sv | 164 ++++++++++++++++
 tb/tb_cdf_store_packer.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cdf_store_packer_if.sv
// Element input and write-port channels of the CDF packing store.
// master = packer side, slave = upstream pipeline plus memory side.
interface cdf_store_packer_if #(
  parameter int RESULT_W = 20,
  parameter int LANE_W   = 16,
  parameter int BUS_W    = 128,
  parameter int ADDR_W   = 16
);
  localparam int LANES = BUS_W / LANE_W;

  logic                StartIn;
  logic [RESULT_W-1:0] ResultIn;
  logic [ADDR_W-1:0]   StoreAddressIn;
  logic                InReady;
  logic                FlushIn;

  logic [BUS_W-1:0]    WriteBus;
  logic [ADDR_W-1:0]   WriteAddress;
  logic [LANES-1:0]    WriteMask;
  logic                WriteEnable;
  logic                WriteReady;

  modport master (
    input  StartIn, ResultIn, StoreAddressIn, FlushIn, WriteReady,
    output InReady, WriteBus, WriteAddress, WriteMask, WriteEnable
  );

  modport slave (
    output StartIn, ResultIn, StoreAddressIn, FlushIn, WriteReady,
    input  InReady, WriteBus, WriteAddress, WriteMask, WriteEnable
  );
endinterface

// File: rtl/cdf_store_packer.sv
// Packs lane-narrowed results into BUS_W words by element address and FIFO-buffers them for a masked write port.
// Closing element shows on WriteEnable next cycle; InReady drops while the FIFO is full. CDF_STORE_SAT_EN: saturate lanes.
module cdf_store_packer #(
  parameter int RESULT_W   = 20,
  parameter int LANE_W     = 16,
  parameter int BUS_W      = 128,
  parameter int ADDR_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset_n,
  cdf_store_packer_if.master     bus,
  output logic                   done
);
  localparam int LANES     = BUS_W / LANE_W;
  localparam int LANE_BITS = $clog2(LANES);
  localparam int PTR_W     = $clog2(FIFO_DEPTH);
  localparam int CNT_W     = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic {EMPTY, PARTIAL} state_t;

  state_t              state_q, state_d;
  logic [BUS_W-1:0]    acc_dat_q, acc_dat_d;
  logic [ADDR_W-1:0]   acc_addr_q, acc_addr_d;
  logic [LANES-1:0]    acc_mask_q, acc_mask_d;

  logic [BUS_W-1:0]    fifo_dat_q  [FIFO_DEPTH];
  logic [BUS_W-1:0]    fifo_dat_d  [FIFO_DEPTH];
  logic [ADDR_W-1:0]   fifo_addr_q [FIFO_DEPTH];
  logic [ADDR_W-1:0]   fifo_addr_d [FIFO_DEPTH];
  logic [LANES-1:0]    fifo_mask_q [FIFO_DEPTH];
  logic [LANES-1:0]    fifo_mask_d [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                done_q, done_d;

  logic [LANE_W-1:0]   lane_val;
  logic [LANE_BITS-1:0] lane_sel;
  logic [ADDR_W-1:0]   word;
  logic [LANES-1:0]    lane_onehot, merged_mask;
  logic [BUS_W-1:0]    lane_dat;
  logic                in_rdy, accept, pop, push;
  logic [BUS_W-1:0]    push_dat;
  logic [ADDR_W-1:0]   push_addr;
  logic [LANES-1:0]    push_mask;

  generate
    if (RESULT_W > LANE_W) begin : g_narrow
`ifdef CDF_STORE_SAT_EN
      assign lane_val = (|bus.ResultIn[RESULT_W-1:LANE_W]) ? '1 : bus.ResultIn[LANE_W-1:0];
`else
      logic unused_hi;
      assign unused_hi = ^bus.ResultIn[RESULT_W-1:LANE_W];
      assign lane_val  = bus.ResultIn[LANE_W-1:0];
`endif
    end else begin : g_wide
      assign lane_val = LANE_W'(bus.ResultIn);
    end
  endgenerate

  assign lane_sel    = bus.StoreAddressIn[LANE_BITS-1:0];
  assign word        = bus.StoreAddressIn >> LANE_BITS;
  assign lane_onehot = LANES'(1) << lane_sel;
  assign merged_mask = acc_mask_q | lane_onehot;
  // No credit for a same-cycle pop keeps the full check a pure register compare.
  assign in_rdy      = (count_q < DEPTH_C);
  assign accept      = bus.StartIn && in_rdy;
  assign pop         = (count_q != '0) && bus.WriteReady;

  always_comb begin
    lane_dat = '0;
    for (int i = 0; i < LANES; i++) begin
      if (lane_onehot[i]) lane_dat[i*LANE_W +: LANE_W] = lane_val;
    end
  end

  always_comb begin
    state_d    = state_q;
    acc_dat_d  = acc_dat_q;
    acc_addr_d = acc_addr_q;
    acc_mask_d = acc_mask_q;
    push       = 1'b0;
    push_dat   = acc_dat_q;
    push_addr  = acc_addr_q;
    push_mask  = acc_mask_q;
    if (accept) begin
      if (state_q == PARTIAL && word == acc_addr_q && !(|(acc_mask_q & lane_onehot))) begin
        acc_dat_d  = acc_dat_q | lane_dat;
        acc_mask_d = merged_mask;
        if (&merged_mask) begin
          push       = 1'b1;
          push_dat   = acc_dat_q | lane_dat;
          push_mask  = merged_mask;
          acc_mask_d = '0;
          state_d    = EMPTY;
        end
      end else begin
        // Word change or lane collision retires the old word; an empty accumulator retires nothing.
        push       = (state_q == PARTIAL);
        acc_dat_d  = lane_dat;
        acc_addr_d = word;
        acc_mask_d = lane_onehot;
        state_d    = PARTIAL;
      end
    end else if (bus.FlushIn && state_q == PARTIAL && in_rdy) begin
      push       = 1'b1;
      acc_mask_d = '0;
      state_d    = EMPTY;
    end
  end

  always_comb begin
    fifo_dat_d  = fifo_dat_q;
    fifo_addr_d = fifo_addr_q;
    fifo_mask_d = fifo_mask_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    if (push) begin
      fifo_dat_d[wr_ptr_q]  = push_dat;
      fifo_addr_d[wr_ptr_q] = push_addr;
      fifo_mask_d[wr_ptr_q] = push_mask;
      wr_ptr_d              = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    done_d  = (state_d == EMPTY) && (count_d == '0);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= EMPTY;
      acc_dat_q   <= '0;
      acc_addr_q  <= '0;
      acc_mask_q  <= '0;
      fifo_dat_q  <= '{default: '0};
      fifo_addr_q <= '{default: '0};
      fifo_mask_q <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      done_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      acc_dat_q   <= acc_dat_d;
      acc_addr_q  <= acc_addr_d;
      acc_mask_q  <= acc_mask_d;
      fifo_dat_q  <= fifo_dat_d;
      fifo_addr_q <= fifo_addr_d;
      fifo_mask_q <= fifo_mask_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      done_q      <= done_d;
    end
  end

  assign bus.InReady      = in_rdy;
  assign bus.WriteEnable  = (count_q != '0);
  assign bus.WriteBus     = fifo_dat_q[rd_ptr_q];
  assign bus.WriteAddress = fifo_addr_q[rd_ptr_q];
  assign bus.WriteMask    = fifo_mask_q[rd_ptr_q];
  assign done             = done_q;
endmodule

// File: tb/tb_cdf_store_packer.sv
// Directed plus random bench for cdf_store_packer with a word-level reference model and write scoreboard.
module tb_cdf_store_packer;
  typedef struct packed {
    logic [15:0]  addr;
    logic [7:0]   mask;
    logic [127:0] data;
  } wr_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic done;

  cdf_store_packer_if #(.RESULT_W(20), .LANE_W(16), .BUS_W(128), .ADDR_W(16)) bus_if ();

  cdf_store_packer #(
    .RESULT_W(20), .LANE_W(16), .BUS_W(128), .ADDR_W(16), .FIFO_DEPTH(4)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus_if),
    .done    (done)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  // reference model state
  wr_t         m_q[$];
  bit          m_open = 0;
  int          m_word = 0;
  logic [7:0]  m_mask = '0;
  logic [15:0] m_lane [8];
  bit          m_done = 1;
  int          n_obs = 0;
  logic [127:0] last_bus;
  logic [15:0]  last_addr;
  logic [7:0]   last_mask;

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] lane_value(int val);
`ifdef CDF_STORE_SAT_EN
    return (val > 65535) ? 16'hFFFF : 16'(val);
`else
    return 16'(val % 65536);
`endif
  endfunction

  task automatic model_push();
    wr_t w;
    w.addr = 16'(m_word);
    w.mask = m_mask;
    w.data = '0;
    for (int l = 0; l < 8; l++)
      if (m_mask[l]) w.data = w.data | (128'(m_lane[l]) << (16 * l));
    m_q.push_back(w);
  endtask

  task automatic model_open(int lane, int word, logic [15:0] lv);
    m_mask = '0;
    m_mask[lane] = 1'b1;
    m_lane[lane] = lv;
    m_word = word;
    m_open = 1;
  endtask

  task automatic model_elem(int addr, int val);
    int lane = addr % 8;
    int word = addr / 8;
    logic [15:0] lv = lane_value(val);
    if (!m_open) model_open(lane, word, lv);
    else if (word == m_word && !m_mask[lane]) begin
      m_lane[lane] = lv;
      m_mask[lane] = 1'b1;
      if (m_mask == 8'hFF) begin
        model_push();
        m_open = 0;
      end
    end else begin
      model_push();
      model_open(lane, word, lv);
    end
  endtask

  // One clock: check DUT against model at negedge, advance model, return after posedge.
  task automatic cycle(output bit accepted);
    bit m_ready;
    bit full_pre;
    @(negedge clock);
    m_ready  = (m_q.size() < 4);
    full_pre = !m_ready;
    chk("in_ready", bus_if.InReady, m_ready);
    chk("write_enable", bus_if.WriteEnable, m_q.size() != 0);
    if (m_q.size() != 0) begin
      chk("write_addr", bus_if.WriteAddress, m_q[0].addr);
      chk("write_mask", bus_if.WriteMask, m_q[0].mask);
      chk("write_bus", bus_if.WriteBus, m_q[0].data);
    end
    chk("done", done, m_done);
    if (bus_if.WriteEnable && bus_if.WriteReady) begin
      n_obs++;
      last_bus  = bus_if.WriteBus;
      last_addr = bus_if.WriteAddress;
      last_mask = bus_if.WriteMask;
    end
    accepted = bus_if.StartIn && m_ready;
    if (bus_if.WriteReady && m_q.size() != 0) void'(m_q.pop_front());
    if (accepted) model_elem(int'(bus_if.StoreAddressIn), int'(bus_if.ResultIn));
    else if (bus_if.FlushIn && m_open && !full_pre) begin
      model_push();
      m_open = 0;
    end
    m_done = !m_open && (m_q.size() == 0);
    @(posedge clock);
    #1;
  endtask

  task automatic send(int addr, int val);
    bit a = 0;
    bus_if.StartIn = 1'b1;
    bus_if.StoreAddressIn = 16'(addr);
    bus_if.ResultIn = 20'(val);
    for (int i = 0; i < 50; i++) begin
      cycle(a);
      if (a) break;
    end
    chk("send_accepted", a, 1'b1);
    bus_if.StartIn = 1'b0;
  endtask

  task automatic flush_until_done();
    bit a;
    bus_if.StartIn = 1'b0;
    bus_if.FlushIn = 1'b1;
    for (int i = 0; i < 40; i++) begin
      cycle(a);
      if (m_done && done) break;
    end
    bus_if.FlushIn = 1'b0;
    chk("flush_done", done, 1'b1);
  endtask

  initial begin
    bit a;
    int base;
    logic [127:0] exp_bus;
    logic [127:0] held_bus;
    bus_if.StartIn = 0;
    bus_if.ResultIn = '0;
    bus_if.StoreAddressIn = '0;
    bus_if.FlushIn = 0;
    bus_if.WriteReady = 1;

    #12;
    chk("rst_we", bus_if.WriteEnable, 1'b0);
    chk("rst_bus", bus_if.WriteBus, 128'h0);
    chk("rst_addr", bus_if.WriteAddress, 16'h0);
    chk("rst_mask", bus_if.WriteMask, 8'h0);
    chk("rst_in_ready", bus_if.InReady, 1'b1);
    chk("rst_done", done, 1'b1);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // full word 0x10..0x17
    for (int k = 0; k < 8; k++) send(16 + k, k + 1);
    exp_bus = 128'h0008_0007_0006_0005_0004_0003_0002_0001;
    chk("t1_we_next_cycle", bus_if.WriteEnable, 1'b1);
    chk("t1_addr", bus_if.WriteAddress, 16'h2);
    chk("t1_mask", bus_if.WriteMask, 8'hFF);
    chk("t1_bus", bus_if.WriteBus, exp_bus);
    flush_until_done();

    // word change then flush
    send(16'h10, 'hA);
    send(16'h11, 'hB);
    send(16'h20, 'hC);
    chk("t2_addr", bus_if.WriteAddress, 16'h2);
    chk("t2_mask", bus_if.WriteMask, 8'h03);
    flush_until_done();
    chk("t2_flush_addr", last_addr, 16'h4);
    chk("t2_flush_mask", last_mask, 8'h01);
    chk("t2_flush_bus", last_bus, 128'hC);

    // lane collision
    send(16'h10, 5);
    send(16'h10, 9);
    chk("t3_first_mask", bus_if.WriteMask, 8'h01);
    chk("t3_first_bus", bus_if.WriteBus, 128'h5);
    flush_until_done();
    chk("t3_second_bus", last_bus, 128'h9);
    chk("t3_second_addr", last_addr, 16'h2);

    // backpressure: 40 full words with a stalled write port at the start
    base = n_obs;
    bus_if.WriteReady = 0;
    for (int k = 0; k < 32; k++) send(16'h100 + k, k + 1);
    chk("t4_in_ready_low", bus_if.InReady, 1'b0);
    held_bus = bus_if.WriteBus;
    bus_if.StartIn = 1'b1;
    bus_if.StoreAddressIn = 16'h120;
    bus_if.ResultIn = 20'd33;
    for (int i = 0; i < 5; i++) cycle(a);
    chk("t4_stall_addr", bus_if.WriteAddress, 16'h20);
    chk("t4_stall_bus", bus_if.WriteBus, held_bus);
    chk("t4_stall_writes", n_obs - base, 0);
    bus_if.WriteReady = 1;
    for (int k = 32; k < 320; k++) send(16'h100 + k, k + 1);
    flush_until_done();
    chk("t4_write_count", n_obs - base, 40);

    // lane narrowing of an over-wide result
    send(16'h30, 'h1ABCD);
    flush_until_done();
`ifdef CDF_STORE_SAT_EN
    chk("t5_lane_value", last_bus, 128'hFFFF);
`else
    chk("t5_lane_value", last_bus, 128'hABCD);
`endif

    // reset with two words buffered
    bus_if.WriteReady = 0;
    for (int k = 0; k < 16; k++) send(16'h40 + k, k + 100);
    chk("t6_buffered_we", bus_if.WriteEnable, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_rst_we", bus_if.WriteEnable, 1'b0);
    chk("t6_rst_done", done, 1'b1);
    chk("t6_rst_in_ready", bus_if.InReady, 1'b1);
    m_q.delete();
    m_open = 0;
    m_done = 1;
    @(posedge clock);
    #2;
    reset_n = 1'b1;
    bus_if.WriteReady = 1;
    base = n_obs;
    for (int i = 0; i < 6; i++) cycle(a);
    chk("t6_no_writes", n_obs - base, 0);

    // random traffic against the model
    for (int i = 0; i < 500; i++) begin
      bus_if.StartIn = ($urandom_range(0, 3) != 0);
      bus_if.StoreAddressIn = 16'($urandom_range(16, 47));
      bus_if.ResultIn = 20'($urandom_range(0, 20'hFFFFF));
      bus_if.FlushIn = ($urandom_range(0, 7) == 0);
      bus_if.WriteReady = ($urandom_range(0, 3) != 0);
      cycle(a);
    end
    bus_if.WriteReady = 1;
    flush_until_done();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
